// File: rtl/hot_page_mig_filter.sv
// ============================================================================
// hot_page_mig_filter
//
// Sits between the hot-page tracker and the migration engine. Each page index
// offered by the tracker is checked against a small history of recently
// issued pages; repeats are dropped. Pages that survive are rate-limited by a
// token bucket, converted to a byte address and presented to the migration
// engine. Saturating statistics counters are exposed for CSR readback.
//
// Only one request is in flight at a time. The input side is ready only while
// the controller is idle.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid and ready are both 1. Once out_valid rises, out_valid and out_addr
// hold steady until that edge. in_ready is combinational from the state
// register only, so it never depends on in_valid.
//
// Ports
//   clk             clock
//   rstn            asynchronous active-low reset
//   in_valid        page offered by the hot tracker (mig_addr_en)
//   in_addr         zero-extended page index (mig_addr)
//   in_ready        accept strobe to the hot tracker (mig_addr_ready)
//   out_valid       migration request valid
//   out_addr        page byte address {page, zeros}
//   out_ready       migration engine accepts the request
//   csr_enable      0: accepted inputs are discarded and never issued
//   csr_clear_hist  one-cycle pulse that invalidates the whole history
//   stat_issued     saturating count of output handshakes
//   stat_dup        saturating count of inputs dropped as history hits
//   stat_throttle   saturating count of cycles stalled on an empty bucket
//   dbg_state       controller state: 0 idle, 1 lookup, 2 wait, 3 issue
//   dbg_credit      current token-bucket level
// ============================================================================
module hot_page_mig_filter #(
    parameter int ADDR_SIZE     = 33,
    parameter int DATA_SIZE     = 21,
    parameter int HIST_DEPTH    = 8,
    parameter int MAX_CREDIT    = 4,
    parameter int REFILL_CYCLES = 256,
    parameter int CNT_W         = 32
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 in_valid,
    input  logic [ADDR_SIZE-1:0]                 in_addr,
    output logic                                 in_ready,
    output logic                                 out_valid,
    output logic [ADDR_SIZE-1:0]                 out_addr,
    input  logic                                 out_ready,
    input  logic                                 csr_enable,
    input  logic                                 csr_clear_hist,
    output logic [CNT_W-1:0]                     stat_issued,
    output logic [CNT_W-1:0]                     stat_dup,
    output logic [CNT_W-1:0]                     stat_throttle,
    output logic [1:0]                           dbg_state,
    output logic [$clog2(MAX_CREDIT+1)-1:0]      dbg_credit
);

    localparam int PTR_W = $clog2(HIST_DEPTH);
    localparam int TMR_W = $clog2(REFILL_CYCLES);
    localparam int CRD_W = $clog2(MAX_CREDIT + 1);
    localparam int OFF_W = ADDR_SIZE - DATA_SIZE;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_WAIT   = 2'd2,
        S_ISSUE  = 2'd3
    } state_t;

    state_t                 state;
    logic [DATA_SIZE-1:0]   cur_page;

    // History: page storage carries no reset, the valid bits decide what counts.
    logic [DATA_SIZE-1:0]   hist_page [HIST_DEPTH];
    logic [HIST_DEPTH-1:0]  hist_valid;
    logic [PTR_W-1:0]       wr_ptr;

    logic [TMR_W-1:0]       refill_tmr;
    logic [CRD_W-1:0]       credit;

    logic                   hist_hit;
    logic                   refill_tick;
    logic                   consume;
    logic                   out_hs;

    // Upper input bits are zero by contract and deliberately ignored.
    logic                   unused_in_upper;
    assign unused_in_upper = ^in_addr[ADDR_SIZE-1:DATA_SIZE];

    assign in_ready    = (state == S_IDLE);
    assign dbg_state   = state;
    assign dbg_credit  = credit;

    assign refill_tick = (refill_tmr == TMR_W'(REFILL_CYCLES - 1));
    assign consume     = (state == S_WAIT) && (credit != '0);
    assign out_hs      = (state == S_ISSUE) && out_ready;

    // Parallel compare of the pending page against every valid history slot.
    always_comb begin
        hist_hit = 1'b0;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (hist_valid[i] && (hist_page[i] == cur_page)) begin
                hist_hit = 1'b1;
            end
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Request controller with registered output port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= S_IDLE;
            cur_page      <= '0;
            out_valid     <= 1'b0;
            out_addr      <= '0;
            stat_issued   <= '0;
            stat_dup      <= '0;
            stat_throttle <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        cur_page <= in_addr[DATA_SIZE-1:0];
                        // With the filter disabled the input is still
                        // consumed so the tracker never stalls.
                        if (csr_enable) begin
                            state <= S_LOOKUP;
                        end
                    end
                end

                S_LOOKUP: begin
                    if (hist_hit) begin
                        stat_dup <= sat_inc(stat_dup);
                        state    <= S_IDLE;
                    end else begin
                        state    <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (credit != '0) begin
                        out_valid <= 1'b1;
                        out_addr  <= {cur_page, {OFF_W{1'b0}}};
                        state     <= S_ISSUE;
                    end else begin
                        stat_throttle <= sat_inc(stat_throttle);
                    end
                end

                S_ISSUE: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        stat_issued <= sat_inc(stat_issued);
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Token bucket. The timer free-runs; a refill landing on the same edge
    // as a consume cancels out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            refill_tmr <= '0;
            credit     <= CRD_W'(MAX_CREDIT);
        end else begin
            refill_tmr <= refill_tick ? '0 : refill_tmr + TMR_W'(1);
            case ({consume, refill_tick})
                2'b10:   credit <= credit - CRD_W'(1);
                2'b01: begin
                    if (credit != CRD_W'(MAX_CREDIT)) begin
                        credit <= credit + CRD_W'(1);
                    end
                end
                default: credit <= credit;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // History bookkeeping. A clear pulse beats a simultaneous record, so a
    // page issued on the clearing edge is not remembered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hist_valid <= '0;
            wr_ptr     <= '0;
        end else if (csr_clear_hist) begin
            hist_valid <= '0;
            wr_ptr     <= '0;
        end else if (out_hs) begin
            hist_valid[wr_ptr] <= 1'b1;
            // HIST_DEPTH is a power of two, so natural wrap overwrites the oldest.
            wr_ptr             <= wr_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (out_hs && !csr_clear_hist) begin
            hist_page[wr_ptr] <= cur_page;
        end
    end

endmodule

// File: tb/tb_hot_page_mig_filter.sv
module tb_hot_page_mig_filter;

    localparam int ADDR_SIZE     = 33;
    localparam int DATA_SIZE     = 21;
    localparam int HIST_DEPTH    = 8;
    localparam int MAX_CREDIT    = 4;
    localparam int REFILL_CYCLES = 256;
    localparam int CNT_W         = 32;
    localparam int OFF_W         = ADDR_SIZE - DATA_SIZE;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b1;
    logic                 in_valid = 1'b0;
    logic [ADDR_SIZE-1:0] in_addr = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [ADDR_SIZE-1:0] out_addr;
    logic                 out_ready = 1'b0;
    logic                 csr_enable = 1'b1;
    logic                 csr_clear_hist = 1'b0;
    logic [CNT_W-1:0]     stat_issued;
    logic [CNT_W-1:0]     stat_dup;
    logic [CNT_W-1:0]     stat_throttle;
    logic [1:0]           dbg_state;
    logic [2:0]           dbg_credit;

    hot_page_mig_filter #(
        .ADDR_SIZE     (ADDR_SIZE),
        .DATA_SIZE     (DATA_SIZE),
        .HIST_DEPTH    (HIST_DEPTH),
        .MAX_CREDIT    (MAX_CREDIT),
        .REFILL_CYCLES (REFILL_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .in_valid       (in_valid),
        .in_addr        (in_addr),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_addr       (out_addr),
        .out_ready      (out_ready),
        .csr_enable     (csr_enable),
        .csr_clear_hist (csr_clear_hist),
        .stat_issued    (stat_issued),
        .stat_dup       (stat_dup),
        .stat_throttle  (stat_throttle),
        .dbg_state      (dbg_state),
        .dbg_credit     (dbg_credit)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    int total = 0;
    int bad   = 0;

    int cyc;          // rising edges since reset release
    int m_credit;     // token bucket level
    int m_issued;
    int m_dup;
    int m_throttle;
    logic [DATA_SIZE-1:0] hist_q[$];   // pages issued since last clear, oldest first
    logic [ADDR_SIZE-1:0] exp_q[$];    // expected out_addr of the pending request

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_hist(input logic [DATA_SIZE-1:0] p);
        foreach (hist_q[i]) begin
            if (hist_q[i] == p) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock edge; the bucket gains a token every REFILL_CYCLES edges,
    // loses one when the request is granted, and never exceeds capacity.
    task automatic step(input bit take);
        @(posedge clk);
        cyc++;
        m_credit = m_credit - (take ? 1 : 0) + (((cyc % REFILL_CYCLES) == 0) ? 1 : 0);
        if (m_credit > MAX_CREDIT) m_credit = MAX_CREDIT;
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        csr_clear_hist = 1'b0;
        rstn           = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_credit", 64'(dbg_credit), 64'(MAX_CREDIT));
        check("rst_out_addr", 64'(out_addr), 64'd0);
        check("rst_stat_issued", 64'(stat_issued), 64'd0);
        check("rst_stat_dup", 64'(stat_dup), 64'd0);
        check("rst_stat_throttle", 64'(stat_throttle), 64'd0);
        @(negedge clk);
        rstn       = 1'b1;
        cyc        = 0;
        m_credit   = MAX_CREDIT;
        m_issued   = 0;
        m_dup      = 0;
        m_throttle = 0;
        hist_q.delete();
        exp_q.delete();
    endtask

    task automatic clear_idle();
        csr_clear_hist = 1'b1;
        step(0);
        csr_clear_hist = 1'b0;
        hist_q.delete();
        check("clr_idle_in_ready", 64'(in_ready), 64'd1);
    endtask

    // Offer one page; hold out_ready low for 'delay' cycles of the issue
    // phase; optionally pulse the history clear on the output handshake edge.
    task automatic issue_req(input logic [DATA_SIZE-1:0] page, input int delay, input bit clr);
        logic [ADDR_SIZE-1:0] exp_addr;
        check("pre_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_addr  = {{OFF_W{1'b0}}, page};
        step(0);
        in_valid = 1'b0;
        if (!csr_enable) begin
            check("dis_in_ready", 64'(in_ready), 64'd1);
            check("dis_out_valid", 64'(out_valid), 64'd0);
            check("dis_stat_issued", 64'(stat_issued), 64'(m_issued));
            check("dis_stat_dup", 64'(stat_dup), 64'(m_dup));
            return;
        end
        check("busy_in_ready", 64'(in_ready), 64'd0);
        if (in_hist(page)) begin
            step(0);
            m_dup++;
            check("dup_in_ready", 64'(in_ready), 64'd1);
            check("dup_out_valid", 64'(out_valid), 64'd0);
            check("dup_stat_dup", 64'(stat_dup), 64'(m_dup));
            return;
        end
        step(0);
        check("wait_out_valid", 64'(out_valid), 64'd0);
        while (m_credit == 0) begin
            m_throttle++;
            step(0);
            check("throttle_out_valid", 64'(out_valid), 64'd0);
        end
        exp_q.push_back({page, {OFF_W{1'b0}}});
        step(1);
        exp_addr = exp_q.pop_front();
        check("issue_out_valid", 64'(out_valid), 64'd1);
        check("issue_out_addr", 64'(out_addr), 64'(exp_addr));
        check("issue_credit", 64'(dbg_credit), 64'(m_credit));
        check("issue_throttle", 64'(stat_throttle), 64'(m_throttle));
        check("issue_in_ready", 64'(in_ready), 64'd0);
        repeat (delay) begin
            step(0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_addr", 64'(out_addr), 64'(exp_addr));
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready      = 1'b1;
        csr_clear_hist = clr;
        step(0);
        out_ready      = 1'b0;
        csr_clear_hist = 1'b0;
        m_issued++;
        if (clr) begin
            hist_q.delete();
        end else begin
            hist_q.push_back(page);
            if (hist_q.size() > HIST_DEPTH) void'(hist_q.pop_front());
        end
        check("hs_out_valid", 64'(out_valid), 64'd0);
        check("hs_in_ready", 64'(in_ready), 64'd1);
        check("hs_stat_issued", 64'(stat_issued), 64'(m_issued));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        #1;
        do_reset();

        // 1) single page, credit drops to 3
        issue_req(21'h00ABC, 0, 1'b0);
        check("t1_credit_is_3", 64'(dbg_credit), 64'd3);

        // 2) repeat of a just-issued page is dropped
        issue_req(21'h1, 0, 1'b0);
        issue_req(21'h1, 0, 1'b0);
        check("t2_stat_dup", 64'(stat_dup), 64'd1);

        // 3) six distinct pages from a full bucket
        do_reset();
        for (int i = 0; i < 6; i++) issue_req(21'h200 + 21'(i), 0, 1'b0);
        check("t3_stat_issued", 64'(stat_issued), 64'd6);
        check("t3_throttle_model", 64'(stat_throttle), 64'(m_throttle));

        // 4) history depth: oldest entry overwritten, newest still remembered
        do_reset();
        for (int i = 0; i < 9; i++) issue_req(21'h100 + 21'(i), 0, 1'b0);
        issue_req(21'h100, 0, 1'b0);
        check("t4_reissued", 64'(stat_issued), 64'd10);
        issue_req(21'h108, 0, 1'b0);
        check("t4_dup", 64'(stat_dup), 64'd1);

        // 5) back-pressure for 10 cycles
        issue_req(21'h1F0F0, 10, 1'b0);

        // 6) clear coinciding with handshake, then same page again
        do_reset();
        issue_req(21'h5, 0, 1'b1);
        issue_req(21'h5, 0, 1'b0);
        check("t6_issued_twice", 64'(stat_issued), 64'd2);
        check("t6_no_dup", 64'(stat_dup), 64'd0);
        csr_enable = 1'b0;
        issue_req(21'h6, 0, 1'b0);
        csr_enable = 1'b1;
        check("t6_dis_issued", 64'(stat_issued), 64'd2);

        // async reset mid-request abandons it, nothing recorded
        in_valid = 1'b1;
        in_addr  = 33'h77;
        step(0);
        in_valid = 1'b0;
        step(0);
        step(1);
        check("ar_out_valid_before", 64'(out_valid), 64'd1);
        do_reset();
        issue_req(21'h77, 0, 1'b0);
        check("ar_not_recorded", 64'(stat_dup), 64'd0);

        // randomized traffic over a small page pool
        for (int n = 0; n < 30; n++) begin
            csr_enable = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 9) == 0) clear_idle();
            issue_req(21'($urandom_range(0, 11)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0));
        end
        csr_enable = 1'b1;
        check("rand_issued", 64'(stat_issued), 64'(m_issued));
        check("rand_dup", 64'(stat_dup), 64'(m_dup));
        check("rand_throttle", 64'(stat_throttle), 64'(m_throttle));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
